// File: rtl/i2s_rx_param.sv
// I2S / left-justified serial audio receiver. It assembles DATA_W-bit words per channel,
// strobes a valid with parity, and flags truncated words.
module i2s_rx_param #(
    parameter int DATA_W  = 16,
    parameter int MODE_LJ = 0
) (
    input  logic              sck,
    input  logic              rst,
    input  logic              sd,
    input  logic              ws,
    output logic              sd_out,
    output logic              wsd,
    output logic              wsp,
    output logic [DATA_W-1:0] left_data,
    output logic [DATA_W-1:0] right_data,
    output logic              left_valid,
    output logic              right_valid,
    output logic              left_par,
    output logic              right_par,
    output logic              short_err
);

    localparam int              CW       = $clog2(DATA_W + 1);
    localparam logic [CW-1:0]   CNT_FULL = CW'(DATA_W);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DATA_W - 1);

    logic              wsdd;
    logic [DATA_W-1:0] shreg;
    logic [CW-1:0]     count;
    logic              chan;
    logic              start;
    logic              start_ch;
    logic [DATA_W-1:0] word;

    assign wsp  = wsd ^ wsdd;
    assign word = {shreg[DATA_W-2:0], sd};

    always_comb begin
        start    = 1'b0;
        start_ch = 1'b0;
        if (MODE_LJ != 0) begin
            start    = ws ^ wsd;
            start_ch = ws;
        end else begin
            start    = wsp;
            start_ch = wsd;
        end
    end

    // count == CNT_FULL doubles as the idle/saturated state between words
    always_ff @(posedge sck or posedge rst) begin
        if (rst) begin
            sd_out      <= 1'b0;
            wsd         <= 1'b0;
            wsdd        <= 1'b0;
            shreg       <= '0;
            count       <= CNT_FULL;
            chan        <= 1'b0;
            left_data   <= '0;
            right_data  <= '0;
            left_valid  <= 1'b0;
            right_valid <= 1'b0;
            left_par    <= 1'b0;
            right_par   <= 1'b0;
            short_err   <= 1'b0;
        end else begin
            sd_out      <= sd;
            wsd         <= ws;
            wsdd        <= wsd;
            left_valid  <= 1'b0;
            right_valid <= 1'b0;
            if (start) begin
                shreg <= {{(DATA_W-1){1'b0}}, sd};
                count <= CW'(1);
                chan  <= start_ch;
                if (count < CNT_FULL) begin
                    short_err <= 1'b1;
                end
            end else if (count < CNT_FULL) begin
                shreg <= word;
                count <= count + CW'(1);
                if (count == CNT_LAST) begin
                    if (chan) begin
                        right_data  <= word;
                        right_par   <= ^word;
                        right_valid <= 1'b1;
                    end else begin
                        left_data  <= word;
                        left_par   <= ^word;
                        left_valid <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
